// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [2:0] {
      BOOT,
      REQ,
      HOLD,
      HALT,
      TRAP
   } state_t;

   localparam logic [1:0]  CAUSE_NONE     = 2'd0;
   localparam logic [1:0]  CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0]  CAUSE_TIMEOUT  = 2'd2;

   localparam logic [31:0] PC_INCR = 32'd4;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register: loads a new value when load_i is set, otherwise holds.
module fetch_sequencer_pc_reg #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_i,
   input  logic [31:0] pc_d_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= RESET_VECTOR;
      end else if (load_i) begin
         pc_q <= pc_d_i;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// RV32I fetch sequencer: PC control, fetch handshake, instruction hold,
// halt handling and trap entry on misaligned redirects or memory timeouts.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned MAX_WAIT     = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ack,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt_req,
   output logic        halted,
   output logic        trap,
   output logic [1:0]  trap_cause
);

   // Count of the last stalled REQ cycle allowed before the timeout trap.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic [1:0]  trap_cause_q, trap_cause_d;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        pc_load;

   fetch_sequencer_pc_reg #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (pc_load),
      .pc_d_i  (pc_next),
      .pc_o    (pc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= BOOT;
         wait_cnt_q   <= '0;
         instr_q      <= '0;
         instr_pc_q   <= '0;
         trap_cause_q <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         instr_q      <= instr_d;
         instr_pc_q   <= instr_pc_d;
         trap_cause_q <= trap_cause_d;
      end
   end

   // Wait counter defaults to zero, so it is clear on every REQ entry.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = '0;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
      trap_cause_d = trap_cause_q;
      pc_load      = 1'b0;
      pc_next      = pc + PC_INCR;
      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (imem_ready) begin
               instr_d    = imem_rdata;
               instr_pc_d = pc;
               state_d    = HOLD;
            end else if (wait_cnt_q == WAIT_LAST) begin
               trap_cause_d = CAUSE_TIMEOUT;
               state_d      = TRAP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (instr_ack) begin
               if (redirect_valid && is_misaligned(redirect_target)) begin
                  trap_cause_d = CAUSE_MISALIGN;
                  state_d      = TRAP;
               end else begin
                  pc_load = 1'b1;
                  if (redirect_valid) begin
                     pc_next = redirect_target;
                  end
                  state_d = halt_req ? HALT : REQ;
               end
            end
         end
         HALT: begin
            if (!halt_req) begin
               state_d = REQ;
            end
         end
         TRAP: begin
            pc_load = 1'b1;
            pc_next = TRAP_VECTOR;
            state_d = REQ;
         end
         default: state_d = BOOT;
      endcase
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc;
   assign instr_valid = (state_q == HOLD);
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign halted      = (state_q == HALT);
   assign trap        = (state_q == TRAP);
   assign trap_cause  = trap_cause_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer; memory returns address XOR KEY.
module tb_fetch_sequencer;

   localparam logic [31:0] KEY = 32'hC0DE_0013;

   logic        clk;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ack;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt_req;
   logic        halted;
   logic        trap;
   logic [1:0]  trap_cause;

   int vectors = 0;
   int miscompares = 0;

   fetch_sequencer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_ack       (instr_ack),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt_req        (halt_req),
      .halted          (halted),
      .trap            (trap),
      .trap_cause      (trap_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ KEY;

   task automatic idle_inputs();
      imem_ready      = 1'b0;
      instr_ack       = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      halt_req        = 1'b0;
   endtask

   // Reset, fetch once at 0, then redirect so the caller starts in REQ at addr.
   task automatic start_at(input logic [31:0] addr);
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready      = 1'b0;
      instr_ack       = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = addr;
      @(negedge clk);
      instr_ack      = 1'b0;
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_inputs();
      #3;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      vectors++; if ({halted, trap, trap_cause} !== 4'b0) begin miscompares++; $display("FAIL rst_flags: got %b expected 0000", {halted, trap, trap_cause}); end
      vectors++; if ({instr, instr_pc} !== 64'h0) begin miscompares++; $display("FAIL rst_instr: got %h expected 0", {instr, instr_pc}); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req: got %b expected 0", imem_req); end
      @(negedge clk);
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL boot_to_req: got %b expected 1", imem_req); end
      $display("test_reset done");
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      imem_ready = 1'b1;
      instr_ack  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_pc = 32'(4 * (k / 2));
         if (k % 2 == 0) begin
            vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin miscompares++; $display("FAIL seq_req[%0d]: got valid=%b req=%b expected valid=0 req=1", k, instr_valid, imem_req); end
            vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL seq_addr[%0d]: got %h expected %h", k, imem_addr, exp_pc); end
         end else begin
            vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL seq_hold[%0d]: got valid=%b req=%b expected valid=1 req=0", k, instr_valid, imem_req); end
            vectors++; if (instr_pc !== exp_pc || instr !== (exp_pc ^ KEY)) begin miscompares++; $display("FAIL seq_instr[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", k, instr_pc, instr, exp_pc, exp_pc ^ KEY); end
         end
         @(negedge clk);
      end
      idle_inputs();
      $display("test_sequential done");
   endtask

   task automatic test_redirect();
      start_at(32'h10);
      vectors++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin miscompares++; $display("FAIL redir_start: got addr=%h req=%b expected addr=00000010 req=1", imem_addr, imem_req); end
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b1 || instr !== (32'h10 ^ KEY) || instr_pc !== 32'h10) begin miscompares++; $display("FAIL redir_hold: got valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=00000010", instr_valid, instr, instr_pc, 32'h10 ^ KEY); end
      instr_ack       = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      @(negedge clk);
      instr_ack      = 1'b0;
      redirect_valid = 1'b0;
      vectors++; if (imem_addr !== 32'h200 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_target: got addr=%h req=%b valid=%b expected addr=00000200 req=1 valid=0", imem_addr, imem_req, instr_valid); end
      $display("test_redirect done");
   endtask

   task automatic test_misalign();
      start_at(32'h10);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready      = 1'b0;
      instr_ack       = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h202;
      @(negedge clk);
      instr_ack      = 1'b0;
      redirect_valid = 1'b0;
      vectors++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin miscompares++; $display("FAIL mis_trap: got trap=%b cause=%0d expected trap=1 cause=1", trap, trap_cause); end
      vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL mis_pc_held: got req=%b addr=%h expected req=0 addr=00000010", imem_req, imem_addr); end
      @(negedge clk);
      vectors++; if (trap !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin miscompares++; $display("FAIL mis_vector: got trap=%b addr=%h req=%b expected trap=0 addr=00000100 req=1", trap, imem_addr, imem_req); end
      vectors++; if (trap_cause !== 2'd1) begin miscompares++; $display("FAIL mis_cause_held: got %0d expected 1", trap_cause); end
      $display("test_misalign done");
   endtask

   task automatic test_timeout();
      start_at(32'h20);
      for (int i = 0; i < 8; i++) begin
         vectors++; if (imem_req !== 1'b1 || trap !== 1'b0 || imem_addr !== 32'h20) begin miscompares++; $display("FAIL tmo_wait[%0d]: got req=%b trap=%b addr=%h expected req=1 trap=0 addr=00000020", i, imem_req, trap, imem_addr); end
         @(negedge clk);
      end
      vectors++; if (trap !== 1'b1 || trap_cause !== 2'd2 || imem_req !== 1'b0) begin miscompares++; $display("FAIL tmo_trap: got trap=%b cause=%0d req=%b expected trap=1 cause=2 req=0", trap, trap_cause, imem_req); end
      @(negedge clk);
      vectors++; if (imem_addr !== 32'h100 || imem_req !== 1'b1 || trap !== 1'b0) begin miscompares++; $display("FAIL tmo_refetch: got addr=%h req=%b trap=%b expected addr=00000100 req=1 trap=0", imem_addr, imem_req, trap); end
      $display("test_timeout done");
   endtask

   task automatic test_ready_late();
      start_at(32'h20);
      for (int i = 0; i < 6; i++) @(negedge clk);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      vectors++; if (instr_valid !== 1'b1 || trap !== 1'b0 || instr_pc !== 32'h20) begin miscompares++; $display("FAIL late_ready: got valid=%b trap=%b pc=%h expected valid=1 trap=0 pc=00000020", instr_valid, trap, instr_pc); end
      vectors++; if (trap_cause !== 2'd0) begin miscompares++; $display("FAIL late_cause: got %0d expected 0", trap_cause); end
      $display("test_ready_late done");
   endtask

   task automatic test_halt();
      start_at(32'h40);
      halt_req = 1'b1;
      @(negedge clk);
      vectors++; if (imem_req !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL halt_in_req: got req=%b halted=%b expected req=1 halted=0", imem_req, halted); end
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      instr_ack  = 1'b1;
      @(negedge clk);
      instr_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_hold[%0d]: got halted=%b req=%b valid=%b expected halted=1 req=0 valid=0", i, halted, imem_req, instr_valid); end
         @(negedge clk);
      end
      halt_req = 1'b0;
      @(negedge clk);
      vectors++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h44) begin miscompares++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected halted=0 req=1 addr=00000044", halted, imem_req, imem_addr); end
      $display("test_halt done");
   endtask

   task automatic test_wrap();
      start_at(32'hFFFF_FFFC);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      vectors++; if (instr_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc: got %h expected fffffffc", instr_pc); end
      instr_ack = 1'b1;
      @(negedge clk);
      instr_ack = 1'b0;
      vectors++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_addr: got addr=%h req=%b expected addr=00000000 req=1", imem_addr, imem_req); end
      $display("test_wrap done");
   endtask

   task automatic test_simultaneous();
      start_at(32'h40);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready      = 1'b0;
      instr_ack       = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h41;
      halt_req        = 1'b1;
      @(negedge clk);
      instr_ack      = 1'b0;
      redirect_valid = 1'b0;
      vectors++; if (trap !== 1'b1 || halted !== 1'b0 || trap_cause !== 2'd1) begin miscompares++; $display("FAIL sim_trap: got trap=%b halted=%b cause=%0d expected trap=1 halted=0 cause=1", trap, halted, trap_cause); end
      @(negedge clk);
      vectors++; if (imem_req !== 1'b1 || halted !== 1'b0 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL sim_refetch: got req=%b halted=%b addr=%h expected req=1 halted=0 addr=00000100", imem_req, halted, imem_addr); end
      halt_req = 1'b0;
      $display("test_simultaneous done");
   endtask

   task automatic test_reset_mid();
      start_at(32'h30);
      for (int i = 0; i < 10; i++) @(negedge clk);
      vectors++; if (trap_cause !== 2'd2 || imem_req !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got cause=%0d req=%b expected cause=2 req=1", trap_cause, imem_req); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || trap_cause !== 2'd0) begin miscompares++; $display("FAIL mid_req_rst: got req=%b addr=%h cause=%0d expected req=0 addr=00000000 cause=0", imem_req, imem_addr, trap_cause); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      vectors++; if (instr_valid !== 1'b1 || instr !== KEY) begin miscompares++; $display("FAIL mid_hold: got valid=%b instr=%h expected valid=1 instr=%h", instr_valid, instr, KEY); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (instr_valid !== 1'b0 || instr !== 32'h0 || trap !== 1'b0) begin miscompares++; $display("FAIL mid_hold_rst: got valid=%b instr=%h trap=%b expected valid=0 instr=00000000 trap=0", instr_valid, instr, trap); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_boot: got req=%b expected 0", imem_req); end
      @(negedge clk);
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart2: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
      $display("test_reset_mid done");
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_sequential();
      test_redirect();
      test_misalign();
      test_timeout();
      test_ready_late();
      test_halt();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter and instruction fetch for the RV32I core over a multi-cycle instruction-memory handshake.
- Issues fetch requests at the current PC and holds each fetched instruction until the core acknowledges it.
- Computes the next PC: sequential +4, redirect (branch/JAL/JALR), or trap vector.
- Handles halt requests, misaligned redirect targets and memory timeouts.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a trap is taken.
- MAX_WAIT, 8, number of REQ cycles without imem_ready before a timeout trap; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals the current PC.
- imem_ready  in  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr  out  32  fetched instruction word.
- instr_pc  out  32  address of instr.
- instr_ack  in  1  core consumes the instruction; meaningful only while instr_valid=1.
- redirect_valid  in  1  the acknowledged instruction changes control flow.
- redirect_target  in  32  new PC; sampled with redirect_valid.
- halt_req  in  1  stop fetching after the current instruction retires.
- halted  out  1  sequencer is in HALT.
- trap  out  1  one-cycle pulse when a trap is taken.
- trap_cause  out  2  0=none, 1=misaligned target, 2=fetch timeout; held until the next trap.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low. While reset_n=0: pc=RESET_VECTOR, state=BOOT, wait counter=0, and every output is 0 except imem_addr (=RESET_VECTOR).
- States: BOOT, REQ, HOLD, HALT, TRAP.
- BOOT: lasts exactly one cycle after reset_n rises, then goes to REQ.
- REQ:
  - imem_req=1; imem_addr=pc, held stable.
  - On imem_ready=1: capture instr<=imem_rdata and instr_pc<=pc, then go to HOLD. instr_valid rises on the next cycle.
  - The wait counter increments for each cycle with imem_ready=0. When the count reaches MAX_WAIT: trap_cause<=2, go to TRAP.
  - The wait counter clears on every entry to REQ.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable until instr_ack.
  - On instr_ack, the next PC is chosen as follows:
    - redirect_valid=1 and redirect_target[1:0]!=0: trap_cause<=1, go to TRAP; pc is not updated.
    - redirect_valid=1 and target aligned: pc<=redirect_target.
    - otherwise: pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - After the PC update: go to HALT if halt_req=1, else to REQ. instr_valid falls the cycle after the ack.
  - redirect_valid is ignored without instr_ack and in every state other than HOLD.
- HALT:
  - halted=1; imem_req=0; pc is held.
  - When halt_req=0, go to REQ at the held pc.
  - halt_req asserted in REQ does not abort the in-flight fetch; it takes effect at the next ack.
- TRAP:
  - Lasts one cycle; trap=1; pc<=TRAP_VECTOR; then go to REQ.
  - The misaligned-target check is not applied to TRAP_VECTOR.
- Timing and throughput:
  - Best-case throughput is one instruction per 2 cycles (REQ with ready, then HOLD with ack).
  - Latency from REQ entry to instr_valid is 1 cycle plus memory wait cycles.
- Reset mid-operation: an asynchronous reset in any state immediately drops imem_req, instr_valid and trap. No partial instruction survives. trap_cause returns to 0.
- Simultaneous events: an instr_ack with a misaligned redirect and halt_req in the same cycle goes to TRAP; halt_req is then re-evaluated at the next ack.

Decomposition:
- Package fetch_pkg:
  - state enum (BOOT, REQ, HOLD, HALT, TRAP);
  - trap cause constants (CAUSE_NONE=0, CAUSE_MISALIGN=1, CAUSE_TIMEOUT=2);
  - PC_INCR=4.
- One sub-module: the team's existing PC register block. It holds pc with the same asynchronous active-low reset, driven by this block's next-PC mux and a load enable. The FSM, wait counter and instruction latch stay in fetch_sequencer.

Test Plan:
- Reset release with imem_ready tied 1 and instr_ack tied 1 -> imem_addr sequence 0x0, 0x4, 0x8, ...; instr_valid toggles every other cycle; instr_pc matches each address.
- Ack at pc=0x10 with redirect_valid=1, target=0x200 -> next imem_addr=0x200; target=0x202 -> trap pulse of one cycle, trap_cause=1, next imem_addr=0x100.
- imem_ready held 0 from REQ entry -> exactly 8 REQ cycles, then trap=1, trap_cause=2, refetch at 0x100; ready on the 7th cycle -> no trap.
- halt_req=1 during HOLD at pc=0x40 with ack -> halted=1 and imem_req=0 until halt_req=0, then imem_addr=0x44.
- pc=0xFFFF_FFFC acked with no redirect -> next imem_addr=0x0.
- reset_n pulsed low mid-REQ with a stalled memory, and again mid-HOLD -> outputs clear immediately; fetch restarts at RESET_VECTOR after one BOOT cycle.
